axi_counter_master: RTL

AXI_COUNTER_MASTER -- requirements
Module: axi_counter_master

---
 rtl/axi_counter_master_if.sv | 56 +++++
 rtl/axi_counter_master.sv | 137 +++++++++++++
 2 files changed

// File: rtl/axi_counter_master_if.sv
// AXI3-style bus bundle between the counter master and its register slave.
// Member names keep the master's point of view (_o driven by master, _i by slave).
interface axi_counter_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [3:0]            awid_o;
    logic [ADDR_WIDTH-1:0] awaddr_o;
    logic                  awvalid_o;
    logic                  awready_i;
    logic [3:0]            wid_o;
    logic [DATA_WIDTH-1:0] wdata_o;
    logic [3:0]            wstrb_o;
    logic                  wlast_o;
    logic                  wvalid_o;
    logic                  wready_i;
    logic [3:0]            bid_i;
    logic [1:0]            bresp_i;
    logic                  bvalid_i;
    logic                  bready_o;
    logic [3:0]            arid_o;
    logic [ADDR_WIDTH-1:0] araddr_o;
    logic                  arvalid_o;
    logic                  arready_i;
    logic [3:0]            rid_i;
    logic [DATA_WIDTH-1:0] rdata_i;
    logic                  rlast_i;
    logic                  rvalid_i;
    logic                  rready_o;

    modport master (
        output awid_o, awaddr_o, awvalid_o,
        input  awready_i,
        output wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o,
        input  wready_i,
        input  bid_i, bresp_i, bvalid_i,
        output bready_o,
        output arid_o, araddr_o, arvalid_o,
        input  arready_i,
        input  rid_i, rdata_i, rlast_i, rvalid_i,
        output rready_o
    );

    modport slave (
        input  awid_o, awaddr_o, awvalid_o,
        output awready_i,
        input  wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o,
        output wready_i,
        output bid_i, bresp_i, bvalid_i,
        input  bready_o,
        input  arid_o, araddr_o, arvalid_o,
        output arready_i,
        output rid_i, rdata_i, rlast_i, rvalid_i,
        input  rready_o
    );
endinterface

// File: rtl/axi_counter_master.sv
// Writes REG_COUNT counter values (seed+idx) to consecutive registers, then reads
// back the slave's CRC register and compares it with the XOR of the acknowledged writes.
module axi_counter_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_COUNT  = 8
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] crc_o,
    output logic                  crc_ok_o,
    output logic                  err_o,
    axi_counter_master_if.master  axi
);

    localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_D, DONE} state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [DATA_WIDTH-1:0] crc_q;
    logic                  aw_hs, w_hs, aw_pend, w_pend, last_reg;
    logic                  unused_ok;

    assign axi.awid_o  = 4'h0;
    assign axi.wid_o   = 4'h0;
    assign axi.arid_o  = 4'h0;
    assign axi.wstrb_o = 4'hF;
    assign axi.wlast_o = 1'b1;
    assign unused_ok   = ^{axi.bid_i, axi.rid_i, axi.rlast_i};

    assign idx_nxt  = idx + 1'b1;
    assign last_reg = (idx == IDX_W'(REG_COUNT - 1));
    assign aw_hs    = axi.awvalid_o & axi.awready_i;
    assign w_hs     = axi.wvalid_o & axi.wready_i;
    // A channel is still outstanding after this edge only if valid is up without ready.
    assign aw_pend  = axi.awvalid_o & ~axi.awready_i;
    assign w_pend   = axi.wvalid_o & ~axi.wready_i;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state         <= IDLE;
            idx           <= '0;
            seed_q        <= '0;
            crc_q         <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            crc_o         <= '0;
            crc_ok_o      <= 1'b0;
            err_o         <= 1'b0;
            axi.awaddr_o  <= '0;
            axi.awvalid_o <= 1'b0;
            axi.wdata_o   <= '0;
            axi.wvalid_o  <= 1'b0;
            axi.bready_o  <= 1'b0;
            axi.araddr_o  <= '0;
            axi.arvalid_o <= 1'b0;
            axi.rready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        seed_q        <= seed_i;
                        idx           <= '0;
                        crc_q         <= '0;
                        err_o         <= 1'b0;
                        crc_o         <= '0;
                        crc_ok_o      <= 1'b0;
                        busy_o        <= 1'b1;
                        axi.awaddr_o  <= '0;
                        axi.wdata_o   <= seed_i;
                        axi.awvalid_o <= 1'b1;
                        axi.wvalid_o  <= 1'b1;
                        state         <= WR;
                    end
                end
                WR: begin
                    if (aw_hs) axi.awvalid_o <= 1'b0;
                    if (w_hs)  axi.wvalid_o  <= 1'b0;
                    if (!aw_pend && !w_pend) begin
                        axi.bready_o <= 1'b1;
                        state        <= WR_B;
                    end
                end
                WR_B: begin
                    if (axi.bvalid_i) begin
                        axi.bready_o <= 1'b0;
                        crc_q        <= crc_q ^ axi.wdata_o;
                        if (axi.bresp_i != 2'b00) err_o <= 1'b1;
                        if (last_reg) begin
                            axi.araddr_o  <= ADDR_WIDTH'(REG_COUNT * 4);
                            axi.arvalid_o <= 1'b1;
                            state         <= RD_A;
                        end else begin
                            idx           <= idx_nxt;
                            axi.awaddr_o  <= ADDR_WIDTH'(idx_nxt) << 2;
                            axi.wdata_o   <= seed_q + DATA_WIDTH'(idx_nxt);
                            axi.awvalid_o <= 1'b1;
                            axi.wvalid_o  <= 1'b1;
                            state         <= WR;
                        end
                    end
                end
                RD_A: begin
                    if (axi.arready_i) begin
                        axi.arvalid_o <= 1'b0;
                        axi.rready_o  <= 1'b1;
                        state         <= RD_D;
                    end
                end
                RD_D: begin
                    if (axi.rvalid_i) begin
                        crc_o        <= axi.rdata_i;
                        crc_ok_o     <= (axi.rdata_i == crc_q);
                        axi.rready_o <= 1'b0;
                        done_o       <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
